// File: rtl/enc16x4_irq.sv
// -----------------------------------------------------------------------------
// enc16x4_irq
//
// Registered 16-to-4 priority encoder with request latching and a valid/ack
// handshake. Active-low request lines are captured into a pending register.
// The highest-index pending request is encoded into y, presented with
// valid=1, and held stable until the consumer acknowledges it. The
// acknowledged pending bit is then cleared and arbitration restarts.
//
// Ports:
//   clk      in   1   rising-edge clock
//   reset    in   1   asynchronous, active-high; clears all state
//   req_n    in  16   request lines, active-low (bit i low = request i)
//   e        in   1   active-low capture enable; high blocks new captures
//   ack      in   1   consumer accepts the current code; ignored while valid=0
//   y        out  4   encoded index of the granted request (registered)
//   valid    out  1   y holds a granted request (registered)
//   pending  out 16   pending-request register, active-high
//
// Configuration macro:
//   ENC_EDGE_DETECT_EN  defined   -> a pending bit is set only on a falling
//                                    edge of its req_n line (req_q history)
//                       undefined -> level capture: set on every edge with the
//                                    line low, so held requests re-grant
// -----------------------------------------------------------------------------
module enc16x4_irq (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] req_n,
    input  logic        e,
    input  logic        ack,
    output logic [3:0]  y,
    output logic        valid,
    output logic [15:0] pending
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  y_q, y_d;
    logic [15:0] pending_q, pending_d;
    logic [15:0] set_vec;
    logic [15:0] clr_vec;

    // Highest set index wins: later loop iterations overwrite earlier ones.
    function automatic logic [3:0] highest_index(input logic [15:0] vec);
        logic [3:0] idx;
        idx = 4'h0;
        for (int i = 0; i < 16; i++) begin
            if (vec[i]) begin
                idx = 4'(i);
            end
        end
        return idx;
    endfunction

`ifdef ENC_EDGE_DETECT_EN
    // Previous-cycle request lines. Tracks req_n every cycle, independent of
    // e, so a request held low through a disabled window is not seen as a
    // new falling edge once capture is re-enabled.
    logic [15:0] req_q;

    // Reset to all-high so a line already low when reset releases counts as
    // a fresh falling edge and is recaptured.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            req_q <= 16'hFFFF;
        end else begin
            req_q <= req_n;
        end
    end

    always_comb begin
        set_vec = 16'h0000;
        if (!e) begin
            set_vec = req_q & ~req_n;
        end
    end
`else
    always_comb begin
        set_vec = 16'h0000;
        if (!e) begin
            set_vec = ~req_n;
        end
    end
`endif

    // Only an accepted grant clears anything, and only its own bit.
    always_comb begin
        clr_vec = 16'h0000;
        if (state_q == HOLD && ack) begin
            clr_vec[y_q] = 1'b1;
        end
    end

    // Set is applied after clear, so a capture colliding with an ack of the
    // same bit leaves that bit pending.
    assign pending_d = (pending_q & ~clr_vec) | set_vec;

    // NOTE: every signal assigned in this block gets a default before the
    // case statement; a path that skips an assignment would infer a latch.
    always_comb begin
        state_d = state_q;
        y_d     = y_q;
        case (state_q)
            IDLE: begin
                // Arbitrate on the registered pending vector, which is what
                // gives the two-edge request-to-valid latency.
                if (pending_q != 16'h0000) begin
                    y_d     = highest_index(pending_q);
                    state_d = HOLD;
                end
            end
            HOLD: begin
                // y is frozen here; captures only accumulate in pending.
                if (ack) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    // NOTE: the pending vector is reset along with the FSM; stale bits left
    // over from before reset would otherwise be granted as phantom requests.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            y_q       <= 4'h0;
            pending_q <= 16'h0000;
        end else begin
            state_q   <= state_d;
            y_q       <= y_d;
            pending_q <= pending_d;
        end
    end

    // valid is a direct decode of the one-bit state register, so it is as
    // glitch-free as a dedicated flop.
    assign y       = y_q;
    assign valid   = (state_q == HOLD);
    assign pending = pending_q;

endmodule

// File: tb/tb_enc16x4_irq.sv
// -----------------------------------------------------------------------------
// tb_enc16x4_irq
//
// Self-checking bench for enc16x4_irq. Directed scenarios check the fixed
// expectations for reset, priority, hold stability, enable masking, set/clear
// collision and reset during a grant; a randomized run compares every cycle
// against a behavioural model of the request/grant rules.
// Honours ENC_EDGE_DETECT_EN in the same way as the design.
// -----------------------------------------------------------------------------
module tb_enc16x4_irq;

    logic        clk;
    logic        reset;
    logic [15:0] req_n;
    logic        e;
    logic        ack;
    logic [3:0]  y;
    logic        valid;
    logic [15:0] pending;

    int total = 0;
    int bad   = 0;

    // Behavioural model state.
    logic        m_valid;
    logic [3:0]  m_y;
    logic [15:0] m_pend;
    logic [15:0] m_prev;

    enc16x4_irq dut (
        .clk     (clk),
        .reset   (reset),
        .req_n   (req_n),
        .e       (e),
        .ack     (ack),
        .y       (y),
        .valid   (valid),
        .pending (pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_clear();
        m_valid = 1'b0;
        m_y     = 4'h0;
        m_pend  = 16'h0000;
        m_prev  = 16'hFFFF;
    endtask

    // One clock edge: work out what the rules say from the pre-edge inputs,
    // wait for the edge, then move 1 time unit past it.
    task automatic tick();
        logic [15:0] captured;
        logic [15:0] next_pend;
        logic        next_valid;
        logic [3:0]  next_y;
        captured = 16'h0000;
        for (int i = 0; i < 16; i++) begin
`ifdef ENC_EDGE_DETECT_EN
            if (!e && req_n[i] == 1'b0 && m_prev[i] == 1'b1) captured[i] = 1'b1;
`else
            if (!e && req_n[i] == 1'b0) captured[i] = 1'b1;
`endif
        end
        next_pend  = m_pend;
        next_valid = m_valid;
        next_y     = m_y;
        if (m_valid && ack) begin
            next_pend[m_y] = 1'b0;
            next_valid     = 1'b0;
        end else if (!m_valid && m_pend != 16'h0000) begin
            // Search downward from the top priority request.
            for (int i = 15; i >= 0; i--) begin
                if (m_pend[i]) begin
                    next_y = 4'(i);
                    break;
                end
            end
            next_valid = 1'b1;
        end
        next_pend = next_pend | captured;
        @(posedge clk);
        m_pend  = next_pend;
        m_valid = next_valid;
        m_y     = next_y;
        m_prev  = req_n;
        #1;
    endtask

    task automatic do_reset(input logic [15:0] r);
        reset = 1'b1;
        req_n = r;
        e     = 1'b0;
        ack   = 1'b0;
        model_clear();
        #3;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_n = 16'h0000;
        e     = 1'b0;
        ack   = 1'b0;
        model_clear();
        #2;
        total++; if (y !== 4'h0) begin bad++; $display("FAIL rst_y: got %h want 0", y); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", valid); end
        total++; if (pending !== 16'h0000) begin bad++; $display("FAIL rst_pending: got %h want 0000", pending); end
        @(posedge clk); #1;
        total++; if (pending !== 16'h0000) begin bad++; $display("FAIL rst_pending_edge: got %h want 0000", pending); end
        #2;
        reset = 1'b0;
        tick();
        total++; if (pending !== 16'hFFFF) begin bad++; $display("FAIL rst_capture: got %h want FFFF", pending); end
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL rst_valid_lat1: got %b want 0", valid); end
        tick();
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL rst_valid_lat2: got %b want 1", valid); end
        total++; if (y !== 4'hF) begin bad++; $display("FAIL rst_first_y: got %h want F", y); end
    endtask

    task automatic test_priority();
        do_reset(16'hFFFF);
        req_n = 16'hFFDB;
        tick();
        total++; if (pending !== 16'h0024) begin bad++; $display("FAIL prio_pend: got %h want 0024", pending); end
        req_n = 16'hFFFF;
        tick();
        total++; if (valid !== 1'b1 || y !== 4'd5) begin bad++; $display("FAIL prio_first: got valid=%b y=%0d want valid=1 y=5", valid, y); end
        ack = 1'b1;
        tick();
        total++; if (valid !== 1'b0 || pending !== 16'h0004) begin bad++; $display("FAIL prio_ack1: got valid=%b pend=%h want valid=0 pend=0004", valid, pending); end
        ack = 1'b0;
        tick();
        total++; if (valid !== 1'b1 || y !== 4'd2) begin bad++; $display("FAIL prio_second: got valid=%b y=%0d want valid=1 y=2", valid, y); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++; if (valid !== 1'b0 || pending !== 16'h0000) begin bad++; $display("FAIL prio_ack2: got valid=%b pend=%h want valid=0 pend=0000", valid, pending); end
        tick();
        tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL prio_idle: got valid=%b want 0", valid); end
    endtask

    task automatic test_hold();
        do_reset(16'hFFFF);
        req_n = 16'hFFF7;
        tick();
        req_n = 16'hFFFF;
        tick();
        total++; if (valid !== 1'b1 || y !== 4'd3) begin bad++; $display("FAIL hold_grant: got valid=%b y=%0d want valid=1 y=3", valid, y); end
        req_n = 16'hEFFF;
        tick();
        req_n = 16'hFFFF;
        total++; if (y !== 4'd3 || pending !== 16'h1008) begin bad++; $display("FAIL hold_pulse: got y=%0d pend=%h want y=3 pend=1008", y, pending); end
        tick();
        tick();
        total++; if (valid !== 1'b1 || y !== 4'd3) begin bad++; $display("FAIL hold_stable: got valid=%b y=%0d want valid=1 y=3", valid, y); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
        total++; if (valid !== 1'b0 || pending !== 16'h1000) begin bad++; $display("FAIL hold_ack: got valid=%b pend=%h want valid=0 pend=1000", valid, pending); end
        tick();
        total++; if (valid !== 1'b1 || y !== 4'd12) begin bad++; $display("FAIL hold_next: got valid=%b y=%0d want valid=1 y=12", valid, y); end
    endtask

    task automatic test_enable();
        do_reset(16'hFFFF);
        e     = 1'b1;
        req_n = 16'h0000;
        for (int i = 0; i < 5; i++) tick();
        total++; if (pending !== 16'h0000 || valid !== 1'b0) begin bad++; $display("FAIL en_masked: got pend=%h valid=%b want pend=0000 valid=0", pending, valid); end
        e = 1'b0;
        tick();
`ifdef ENC_EDGE_DETECT_EN
        total++; if (pending !== 16'h0000) begin bad++; $display("FAIL en_open: got %h want 0000", pending); end
`else
        total++; if (pending !== 16'hFFFF) begin bad++; $display("FAIL en_open: got %h want FFFF", pending); end
`endif
    endtask

    task automatic test_collision();
        do_reset(16'hFFFF);
        req_n = 16'hFF7F;
        tick();
        tick();
        total++; if (valid !== 1'b1 || y !== 4'd7) begin bad++; $display("FAIL coll_grant: got valid=%b y=%0d want valid=1 y=7", valid, y); end
        ack = 1'b1;
        tick();
        ack = 1'b0;
`ifdef ENC_EDGE_DETECT_EN
        total++; if (pending !== 16'h0000 || valid !== 1'b0) begin bad++; $display("FAIL coll_ack: got pend=%h valid=%b want pend=0000 valid=0", pending, valid); end
        tick();
        tick();
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL coll_regrant: got valid=%b want 0", valid); end
`else
        total++; if (pending !== 16'h0080 || valid !== 1'b0) begin bad++; $display("FAIL coll_ack: got pend=%h valid=%b want pend=0080 valid=0", pending, valid); end
        tick();
        total++; if (valid !== 1'b1 || y !== 4'd7) begin bad++; $display("FAIL coll_regrant: got valid=%b y=%0d want valid=1 y=7", valid, y); end
`endif
        req_n = 16'hFFFF;
    endtask

    task automatic test_reset_mid_hold();
        do_reset(16'hFFFF);
        req_n = 16'hFDFF;
        tick();
        tick();
        total++; if (valid !== 1'b1 || y !== 4'd9) begin bad++; $display("FAIL midrst_grant: got valid=%b y=%0d want valid=1 y=9", valid, y); end
        #2;
        reset = 1'b1;
        model_clear();
        #1;
        total++; if (valid !== 1'b0 || y !== 4'h0 || pending !== 16'h0000) begin bad++; $display("FAIL midrst_async: got valid=%b y=%h pend=%h want 0/0/0000", valid, y, pending); end
        @(posedge clk); #1;
        #2;
        reset = 1'b0;
        tick();
        total++; if (pending !== 16'h0200) begin bad++; $display("FAIL midrst_recapture: got %h want 0200", pending); end
        tick();
        total++; if (valid !== 1'b1 || y !== 4'd9) begin bad++; $display("FAIL midrst_regrant: got valid=%b y=%0d want valid=1 y=9", valid, y); end
        req_n = 16'hFFFF;
    endtask

    task automatic test_random();
        do_reset(16'hFFFF);
        for (int n = 0; n < 300; n++) begin
            req_n = ~(16'($urandom) & 16'($urandom) & 16'($urandom));
            e     = ($urandom_range(0, 3) == 0);
            ack   = 1'($urandom_range(0, 1));
            tick();
            total++; if (valid !== m_valid) begin bad++; $display("FAIL rand_valid[%0d]: got %b want %b", n, valid, m_valid); end
            total++; if (valid === 1'b1 && y !== m_y) begin bad++; $display("FAIL rand_y[%0d]: got %0d want %0d", n, y, m_y); end
            total++; if (pending !== m_pend) begin bad++; $display("FAIL rand_pending[%0d]: got %h want %h", n, pending, m_pend); end
        end
        ack   = 1'b0;
        req_n = 16'hFFFF;
    endtask

    initial begin
        reset = 1'b1;
        req_n = 16'hFFFF;
        e     = 1'b1;
        ack   = 1'b0;
        model_clear();
        test_reset();
        test_priority();
        test_hold();
        test_enable();
        test_collision();
        test_reset_mid_hold();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
